// File: rtl/demux_pkg.sv
// Shared select encodings and output count for the 1-to-4 lane demultiplexer.
package demux_pkg;

  localparam int N_OUT = 4;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_W = 2'd0;
  localparam sel_t SEL_X = 2'd1;
  localparam sel_t SEL_Y = 2'd2;
  localparam sel_t SEL_Z = 2'd3;

endpackage

// File: rtl/demux_decoder.sv
// Combinational select decoder: 2-bit destination select to one-hot output enable.
module demux_decoder
  import demux_pkg::*;
(
  input  logic [1:0]       sel,
  output logic [N_OUT-1:0] en
);

  always_comb begin
    en = '0;
    case (sel)
      SEL_W:   en[0] = 1'b1;
      SEL_X:   en[1] = 1'b1;
      SEL_Y:   en[2] = 1'b1;
      SEL_Z:   en[3] = 1'b1;
      default: en = '0;
    endcase
  end

endmodule

// File: rtl/demultiplexer.sv
// Registered 1-to-4 demultiplexer: A is steered to the output addressed by SEL, others cleared.
// One-cycle latency, a new word every cycle, no stall path.
module demultiplexer
  import demux_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [1:0]        SEL,
  output logic [DATA_W-1:0] W,
  output logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y,
  output logic [DATA_W-1:0] Z
);

  logic [N_OUT-1:0]             en;
  logic [N_OUT-1:0][DATA_W-1:0] out_nxt;
  logic [N_OUT-1:0][DATA_W-1:0] out_q;

  demux_decoder u_decoder (
    .sel (SEL),
    .en  (en)
  );

  // Masking with the one-hot enable guarantees unselected lanes load zero on the same edge.
  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign out_nxt[i] = {DATA_W{en[i]}} & A;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q[i] <= '0;
      end else begin
        out_q[i] <= out_nxt[i];
      end
    end
  end

  assign W = out_q[SEL_W];
  assign X = out_q[SEL_X];
  assign Y = out_q[SEL_Y];
  assign Z = out_q[SEL_Z];

endmodule

// File: tb/tb_demultiplexer.sv
// Self-checking bench for demultiplexer: directed scenarios, full sweep, then randomized traffic.
module tb_demultiplexer;

  localparam int DATA_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] A = '0;
  logic [1:0]        SEL = '0;
  logic [DATA_W-1:0] W, X, Y, Z;

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_q[4];
  bit    have_prev = 1'b0;
  string nm[4] = '{"W", "X", "Y", "Z"};

  demultiplexer #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .SEL   (SEL),
    .W     (W),
    .X     (X),
    .Y     (Y),
    .Z     (Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int out_of(input int i);
    case (i)
      0:       return int'(W);
      1:       return int'(X);
      2:       return int'(Y);
      default: return int'(Z);
    endcase
  endfunction

  // Drive one cycle of stimulus; confirm outputs hold until the edge, then match the model after it.
  task automatic apply(input bit r, input int s, input int a, input string tag);
    int nz;
    int exp_nz;
    rst_n = r;
    SEL   = 2'(s);
    A     = DATA_W'(a);
    #1;
    if (have_prev) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_hold_%s", tag, nm[i]), out_of(i), exp_q[i]);
    end
    for (int i = 0; i < 4; i++)
      exp_q[i] = (r && i == s) ? a : 0;
    have_prev = 1'b1;
    @(posedge clk);
    #1;
    nz = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_%s", tag, nm[i]), out_of(i), exp_q[i]);
      if (out_of(i) != 0) nz++;
    end
    exp_nz = (r && a != 0) ? 1 : 0;
    check($sformatf("%s_onehot", tag), nz, exp_nz);
  endtask

  initial begin
    apply(1'b0, 2, 3, "t1_rst0");
    apply(1'b0, 2, 3, "t1_rst1");
    apply(1'b1, 0, 0, "t2_zero");
    apply(1'b1, 1, 1, "t3_x1");
    apply(1'b1, 2, 1, "t4_y1");
    apply(1'b1, 3, 3, "t4_z3");
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 4; a++)
        apply(1'b1, s, a, $sformatf("t5_s%0d_a%0d", s, a));
    apply(1'b1, 3, 2, "t6_pre");
    apply(1'b0, 3, 2, "t6_rst");
    apply(1'b1, 3, 2, "t6_post");
    for (int k = 0; k < 200; k++)
      apply($urandom_range(15) != 0, int'($urandom_range(3)), int'($urandom_range(3)),
            $sformatf("rnd%0d", k));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
